// File: rtl/bp_common_pkg.sv
// Shared BlackParrot constants and types; this slice carries the CLINT map and decode helpers.
package bp_common_pkg;

  localparam logic [15:0] clint_msip_offset_gp     = 16'h0000;
  localparam logic [15:0] clint_mtimecmp_offset_gp = 16'h4000;
  localparam logic [15:0] clint_mtime_offset_gp    = 16'hBFF8;
  localparam int unsigned clint_hart_stride_gp     = 8;

  // Absolute addresses are derived from the device base so they cannot drift from the offsets
  localparam int unsigned  paddr_width_gp           = 40;
  localparam logic [39:0]  clint_dev_base_addr_gp   = 40'h00_0030_0000;
  localparam logic [39:0]  ipi_reg_base_addr_gp     = clint_dev_base_addr_gp + 40'(clint_msip_offset_gp);
  localparam logic [39:0]  mtimecmp_reg_base_addr_gp = clint_dev_base_addr_gp + 40'(clint_mtimecmp_offset_gp);
  localparam logic [39:0]  mtime_reg_addr_gp        = clint_dev_base_addr_gp + 40'(clint_mtime_offset_gp);

  localparam logic [0:0] clint_state_ready = 1'b0;
  localparam logic [0:0] clint_state_resp  = 1'b1;

  typedef enum logic [1:0] {
    e_clint_msip,
    e_clint_mtimecmp,
    e_clint_mtime,
    e_clint_unmapped
  } clint_region_e;

  typedef struct packed {
    clint_region_e region;
    logic [3:0]    hart;
  } clint_decode_s;

  // Map a 16-bit device offset onto a register region and hart index; low 3 bits are ignored
  function automatic clint_decode_s clint_decode(input logic [15:0] off, input int unsigned num_core);
    clint_decode_s d;
    logic [10:0]   hart_full;
    hart_full = off[13:3];
    d.hart    = hart_full[3:0];
    d.region  = e_clint_unmapped;
    if (off[15:3] == clint_mtime_offset_gp[15:3])
      d.region = e_clint_mtime;
    else if ((off[15:14] == clint_msip_offset_gp[15:14]) && (32'(hart_full) < num_core))
      d.region = e_clint_msip;
    else if ((off[15:14] == clint_mtimecmp_offset_gp[15:14]) && (32'(hart_full) < num_core))
      d.region = e_clint_mtimecmp;
    return d;
  endfunction

endpackage

// File: rtl/bp_clint_tick_gen.sv
// mtime prescaler: one-cycle tick every div_p clocks; constant high when div_p is 1.
module bp_clint_tick_gen #(
  parameter int unsigned div_p = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  if (div_p <= 1) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ reset_i;
    assign tick_o = 1'b1;
  end else begin : g_div
    localparam int unsigned cnt_w = $clog2(div_p);
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(div_p - 1);

    logic [cnt_w-1:0] cnt_r;

    always_ff @(posedge clk_i) begin
      if (reset_i)
        cnt_r <= '0;
      else if (cnt_r == cnt_max)
        cnt_r <= '0;
      else
        cnt_r <= cnt_r + cnt_w'(1);
    end

    assign tick_o = (cnt_r == cnt_max);
  end

endmodule

// File: rtl/bp_clint_multicore.sv
// Core-local interruptor: mtime, per-hart mtimecmp/msip, and a single-outstanding request port.
module bp_clint_multicore
  import bp_common_pkg::*;
#(
  parameter int unsigned num_core_p       = 4,
  parameter int unsigned dword_width_p    = 64,
  parameter int unsigned dev_addr_width_p = 16,
  parameter int unsigned mtime_div_p      = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        req_v_i,
  output logic                        req_ready_o,
  input  logic                        req_w_i,
  input  logic [dev_addr_width_p-1:0] req_addr_i,
  input  logic [dword_width_p-1:0]    req_data_i,
  output logic                        resp_v_o,
  output logic [dword_width_p-1:0]    resp_data_o,
  output logic                        resp_err_o,
  input  logic                        resp_yumi_i,
  output logic [num_core_p-1:0]       timer_irq_o,
  output logic [num_core_p-1:0]       soft_irq_o
);

  localparam int unsigned hart_w = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  logic [0:0]               state_r, state_n;
  logic                     req_ready_r, resp_v_r, resp_err_r;
  logic [dword_width_p-1:0] resp_data_r;
  logic [dword_width_p-1:0] mtime_r;
  logic [dword_width_p-1:0] mtimecmp_r [num_core_p];
  logic [num_core_p-1:0]    msip_r;
  logic [num_core_p-1:0]    timer_irq_r, soft_irq_r;
  logic [num_core_p-1:0]    timer_cmp_c;

  logic                     tick;
  logic                     upper_zero;
  logic                     accept;
  clint_decode_s            dec;
  logic [hart_w-1:0]        hart_idx;
  logic [dword_width_p-1:0] rd_data;
  logic                     wr_msip, wr_mtimecmp, wr_mtime;

  bp_clint_tick_gen #(.div_p(mtime_div_p)) u_tick (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .tick_o (tick)
  );

  // Offsets wider than 16 bits must have zero upper bits to hit a register
  if (dev_addr_width_p > 16) begin : g_wide_addr
    assign upper_zero = ~|req_addr_i[dev_addr_width_p-1:16];
  end else begin : g_narrow_addr
    assign upper_zero = 1'b1;
  end

  always_comb begin
    dec = clint_decode(16'(req_addr_i), num_core_p);
    if (!upper_zero)
      dec.region = e_clint_unmapped;
  end

  assign hart_idx    = hart_w'(dec.hart);
  assign accept      = (state_r == clint_state_ready) && req_v_i;
  assign wr_msip     = accept && req_w_i && (dec.region == e_clint_msip);
  assign wr_mtimecmp = accept && req_w_i && (dec.region == e_clint_mtimecmp);
  assign wr_mtime    = accept && req_w_i && (dec.region == e_clint_mtime);

  // Read mux samples the pre-edge register contents
  always_comb begin
    rd_data = '0;
    case (dec.region)
      e_clint_msip:     rd_data = dword_width_p'(msip_r[hart_idx]);
      e_clint_mtimecmp: rd_data = mtimecmp_r[hart_idx];
      e_clint_mtime:    rd_data = mtime_r;
      default:          rd_data = '0;
    endcase
  end

  always_comb begin
    timer_cmp_c = '0;
    for (int i = 0; i < int'(num_core_p); i++)
      timer_cmp_c[i] = (mtime_r >= mtimecmp_r[i]);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state_r <= clint_state_ready;
    else
      state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      clint_state_ready: if (req_v_i)     state_n = clint_state_resp;
      clint_state_resp:  if (resp_yumi_i) state_n = clint_state_ready;
      default:           state_n = clint_state_ready;
    endcase
  end

  // Handshake flags track the next state so they line up with state_r
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_ready_r <= 1'b1;
      resp_v_r    <= 1'b0;
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
    end else begin
      req_ready_r <= (state_n == clint_state_ready);
      resp_v_r    <= (state_n == clint_state_resp);
      if (accept) begin
        resp_data_r <= req_w_i ? '0 : rd_data;
        resp_err_r  <= (dec.region == e_clint_unmapped);
      end
    end
  end

  // Software mtime writes win over a coincident tick
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mtime_r     <= '0;
      msip_r      <= '0;
      timer_irq_r <= '0;
      soft_irq_r  <= '0;
      for (int i = 0; i < int'(num_core_p); i++)
        mtimecmp_r[i] <= '1;
    end else begin
      if (wr_mtime)
        mtime_r <= req_data_i;
      else if (tick)
        mtime_r <= mtime_r + dword_width_p'(1);
      if (wr_msip)
        msip_r[hart_idx] <= req_data_i[0];
      if (wr_mtimecmp)
        mtimecmp_r[hart_idx] <= req_data_i;
      timer_irq_r <= timer_cmp_c;
      soft_irq_r  <= msip_r;
    end
  end

  assign req_ready_o = req_ready_r;
  assign resp_v_o    = resp_v_r;
  assign resp_data_o = resp_data_r;
  assign resp_err_o  = resp_err_r;
  assign timer_irq_o = timer_irq_r;
  assign soft_irq_o  = soft_irq_r;

endmodule

// File: tb/tb_bp_clint_multicore.sv
// Drives two CLINTs (prescale 8 and 1) with shared requests and checks them against a register-map model.
module tb_bp_clint_multicore;

  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic reset;
  logic req_v, req_w, resp_yumi;
  logic [15:0] req_addr;
  logic [63:0] req_data;

  logic          rdy [2];
  logic          rv  [2];
  logic [63:0]   rdata [2];
  logic          rerr [2];
  logic [NC-1:0] tirq [2];
  logic [NC-1:0] sirq [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: architectural registers only
  logic [63:0]   m_mtime [2];
  logic [63:0]   m_cmp [NC];
  logic [NC-1:0] m_msip;
  bit            m_ready;
  int unsigned   m_edges;
  logic [NC-1:0] exp_t [2];
  logic [NC-1:0] exp_s;

  logic [63:0] last_rd [2];
  logic        last_err;

  always #5 clk = ~clk;

  bp_clint_multicore #(.num_core_p(NC), .dword_width_p(64), .dev_addr_width_p(16), .mtime_div_p(8)) u_dut8 (
    .clk_i(clk), .reset_i(reset), .req_v_i(req_v), .req_ready_o(rdy[0]), .req_w_i(req_w),
    .req_addr_i(req_addr), .req_data_i(req_data), .resp_v_o(rv[0]), .resp_data_o(rdata[0]),
    .resp_err_o(rerr[0]), .resp_yumi_i(resp_yumi), .timer_irq_o(tirq[0]), .soft_irq_o(sirq[0])
  );

  bp_clint_multicore #(.num_core_p(NC), .dword_width_p(64), .dev_addr_width_p(16), .mtime_div_p(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .req_v_i(req_v), .req_ready_o(rdy[1]), .req_w_i(req_w),
    .req_addr_i(req_addr), .req_data_i(req_data), .resp_v_o(rv[1]), .resp_data_o(rdata[1]),
    .resp_err_o(rerr[1]), .resp_yumi_i(resp_yumi), .timer_irq_o(tirq[1]), .soft_irq_o(sirq[1])
  );

  function automatic int unsigned div_of(input int d);
    return (d == 0) ? 8 : 1;
  endfunction

  // 0 = msip, 1 = mtimecmp, 2 = mtime, 3 = unmapped
  function automatic int region_of(input logic [15:0] a);
    int o;
    o = int'(a) & 'hFFF8;
    if (o == 'hBFF8) return 2;
    if (o < 8 * NC) return 0;
    if (o >= 'h4000 && o < 'h4000 + 8 * NC) return 1;
    return 3;
  endfunction

  function automatic int hart_of(input logic [15:0] a);
    int o;
    o = int'(a) & 'hFFF8;
    return (o >= 'h4000) ? (o - 'h4000) / 8 : o / 8;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_mtime[d] <= '0;
        exp_t[d]   <= '0;
      end
      for (int i = 0; i < NC; i++) m_cmp[i] <= '1;
      m_msip  <= '0;
      exp_s   <= '0;
      m_ready <= 1'b1;
      m_edges <= 0;
    end else begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < NC; i++)
          exp_t[d][i] <= (m_mtime[d] >= m_cmp[i]);
      exp_s <= m_msip;
      for (int d = 0; d < 2; d++) begin
        if (m_ready && req_v && req_w && region_of(req_addr) == 2)
          m_mtime[d] <= req_data;
        else if (m_edges % div_of(d) == div_of(d) - 1)
          m_mtime[d] <= m_mtime[d] + 64'd1;
      end
      if (m_ready && req_v && req_w) begin
        if (region_of(req_addr) == 0) m_msip[hart_of(req_addr)] <= req_data[0];
        if (region_of(req_addr) == 1) m_cmp[hart_of(req_addr)]  <= req_data;
      end
      m_edges <= m_edges + 1;
      if (m_ready && req_v) m_ready <= 1'b0;
      else if (!m_ready && resp_yumi) m_ready <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check_eq($sformatf("timer_irq%0d", d), 64'(tirq[d]), 64'(exp_t[d]));
        check_eq($sformatf("soft_irq%0d", d), 64'(sirq[d]), 64'(exp_s));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the yumi edge
  task automatic txn(input bit w, input logic [15:0] a, input logic [63:0] data, input int hold);
    logic [63:0] ed [2];
    bit ee;
    int r, h;
    r  = region_of(a);
    h  = hart_of(a);
    ee = (r == 3);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("req_ready%0d", k), 64'(rdy[k]), 64'd1);
      if (w || ee)     ed[k] = '0;
      else if (r == 0) ed[k] = 64'(m_msip[h]);
      else if (r == 1) ed[k] = m_cmp[h];
      else             ed[k] = m_mtime[k];
    end
    req_v = 1'b1; req_w = w; req_addr = a; req_data = data;
    @(negedge clk);
    req_v = 1'b0;
    for (int c = 0; c <= hold; c++) begin
      for (int k = 0; k < 2; k++) begin
        check_eq($sformatf("resp_v%0d", k), 64'(rv[k]), 64'd1);
        check_eq($sformatf("resp_ready%0d", k), 64'(rdy[k]), 64'd0);
        check_eq($sformatf("resp_data%0d@%04h", k, a), rdata[k], ed[k]);
        check_eq($sformatf("resp_err%0d@%04h", k, a), 64'(rerr[k]), 64'(ee));
        last_rd[k] = rdata[k];
      end
      last_err = rerr[0];
      if (c == hold) resp_yumi = 1'b1;
      @(negedge clk);
    end
    resp_yumi = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [63:0] v;
    int kind;
    reset = 1'b1; req_v = 1'b0; req_w = 1'b0; req_addr = '0; req_data = '0; resp_yumi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check_eq("reset_resp_v", 64'(rv[k]), 64'd0);
      check_eq("reset_resp_data", rdata[k], 64'd0);
    end

    // Idle prescaler behaviour
    idle(80);
    txn(1'b0, 16'hBFF8, '0, 0);
    check_eq("mtime_div8_after80", last_rd[0], 64'd10);
    txn(1'b0, 16'h4008, '0, 0);
    check_eq("mtimecmp1_reset", last_rd[0], 64'hFFFF_FFFF_FFFF_FFFF);

    // Timer interrupt on hart 1
    txn(1'b1, 16'hBFF8, 64'd5, 0);
    txn(1'b1, 16'h4008, 64'd20, 0);
    idle(30);
    check_eq("timer_irq_div1_hart1", 64'(tirq[1]), 64'h2);
    check_eq("timer_irq_div8_none", 64'(tirq[0]), 64'h0);
    txn(1'b1, 16'h4008, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check_eq("timer_irq_cleared", 64'(tirq[1]), 64'h0);

    // Software interrupt on hart 3
    txn(1'b1, 16'h0018, 64'h3, 0);
    check_eq("soft_irq_hart3", 64'(sirq[1]), 64'h8);
    txn(1'b0, 16'h0018, '0, 0);
    check_eq("msip3_readback", last_rd[0], 64'h1);
    txn(1'b1, 16'h0018, 64'h0, 0);
    check_eq("soft_irq_cleared", 64'(sirq[0]), 64'h0);

    // mtime wrap
    txn(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    txn(1'b0, 16'hBFF8, '0, 0);
    check_eq("mtime_all_ones", last_rd[1], 64'hFFFF_FFFF_FFFF_FFFF);
    txn(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    txn(1'b0, 16'hBFF8, '0, 0);
    check_eq("mtime_wrapped", last_rd[1], 64'd0);

    // mtime write coinciding with a tick on the div-8 instance
    for (int i = 0; i < 8 && (m_edges % 8) != 7; i++) @(negedge clk);
    txn(1'b1, 16'hBFF8, 64'd1000, 0);
    txn(1'b0, 16'hBFF8, '0, 0);
    check_eq("mtime_write_beats_tick", last_rd[0], 64'd1000);

    // Unmapped offsets
    txn(1'b0, 16'h0020, '0, 0);
    check_eq("unmapped_0020_err", 64'(last_err), 64'd1);
    txn(1'b0, 16'h8000, '0, 0);
    check_eq("unmapped_8000_data", last_rd[0], 64'd0);
    txn(1'b1, 16'h0020, 64'h1, 0);
    txn(1'b1, 16'h8000, 64'h0, 0);
    txn(1'b1, 16'h4020, 64'h0, 0);
    idle(2);
    check_eq("unmapped_write_no_soft", 64'(sirq[0]), 64'h0);

    // Back-pressure
    txn(1'b0, 16'h4000, '0, 5);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: a = 16'(8 * $urandom_range(0, NC + 1));
        1: a = 16'h4000 + 16'(8 * $urandom_range(0, NC + 1));
        2: a = 16'hBFF8;
        3: a = 16'($urandom_range(0, 16'hFFFF));
        default: a = 16'h4000 + 16'(8 * $urandom_range(0, NC - 1));
      endcase
      a = a | 16'($urandom_range(0, 7));
      if (kind == 2) v = 64'($urandom_range(0, 200));
      else if (kind == 0) v = 64'($urandom_range(0, 3));
      else v = m_mtime[$urandom_range(0, 1)] + 64'($urandom_range(0, 40));
      txn(1'($urandom_range(0, 1)), a, v, int'($urandom_range(0, 2)));
      idle(int'($urandom_range(0, 3)));
    end

    // Reset while a response is pending
    req_v = 1'b1; req_w = 1'b0; req_addr = 16'hBFF8;
    @(negedge clk);
    req_v = 1'b0;
    check_eq("pre_reset_resp_v", 64'(rv[0]), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("post_reset_resp_v%0d", k), 64'(rv[k]), 64'd0);
      check_eq($sformatf("post_reset_ready%0d", k), 64'(rdy[k]), 64'd1);
    end
    txn(1'b0, 16'hBFF8, '0, 0);
    txn(1'b0, 16'h4010, '0, 0);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_clint_multicore.md
Name: bp_clint_multicore

Overview:
- Core-local interruptor serving num_core_p harts. Occupies the clint device slot, base 0x0030_0000.
- Holds one free-running mtime counter with a configurable prescaler. Holds one mtimecmp register and one msip register per hart.
- Drives per-hart timer and software interrupts. The uncached I/O path reaches it through a single-outstanding valid/ready request and response port.

Parameters:
- num_core_p, 4, number of harts. Legal range is 1..16.
- dword_width_p, 64, register and data width.
- dev_addr_width_p, 16, device-offset address width (low bits of the physical address).
- mtime_div_p, 8, clk cycles per mtime increment. Must be ≥1; 1 means increment every cycle.

Ports:
- clk_i  in  1  core clock
- reset_i  in  1  synchronous active-high reset
- req_v_i  in  1  request valid
- req_ready_o  out  1  block can accept a request this cycle
- req_w_i  in  1  1 = write, 0 = read
- req_addr_i  in  dev_addr_width_p  byte offset within the device. Low 3 bits are ignored; access is dword-aligned.
- req_data_i  in  dword_width_p  write data
- resp_v_o  out  1  response valid
- resp_data_o  out  dword_width_p  read data; 0 for writes
- resp_err_o  out  1  access hit an unmapped offset
- resp_yumi_i  in  1  consumer takes the response this cycle
- timer_irq_o  out  num_core_p  per-hart machine timer interrupt
- soft_irq_o  out  num_core_p  per-hart machine software interrupt

Behaviour:
- Register map (offset, hart i):
  - msip[i] at 0x0000 + 8*i. Only bit 0 is stored. Reads zero-extend.
  - mtimecmp[i] at 0x4000 + 8*i, full 64 bits.
  - mtime at 0xBFF8, full 64 bits.
  - Any other offset, including hart index ≥ num_core_p, is unmapped:
    - reads return 0 with resp_err_o=1;
    - writes are dropped with resp_err_o=1.
- Reset values, taking effect on the clock edge while reset_i=1:
  - mtime=0, prescale counter=0, msip[*]=0, mtimecmp[*]=all-ones;
  - FSM=READY, resp_v_o=0, resp_data_o=0, resp_err_o=0;
  - timer_irq_o=0, soft_irq_o=0.
  - Reset asserted mid-transaction discards any pending response.
- Request FSM has two states, READY and RESP.
  - READY: req_ready_o=1. When req_v_i is high, the request is accepted at the clock edge and the FSM moves to RESP. Writes commit at that same edge. Reads sample the register value as it was before that edge.
  - RESP: req_ready_o=0 and resp_v_o=1. resp_data_o and resp_err_o are registered and held stable until resp_yumi_i. On resp_yumi_i the FSM returns to READY.
  - A new request can be accepted no earlier than the cycle after yumi. Minimum spacing is 2 cycles per transaction.
  - Latency: resp_v_o rises 1 cycle after acceptance.
- Prescaler: tick pulses on the cycle the counter equals mtime_div_p-1, and the counter then wraps to 0. If mtime_div_p=1, tick is constant 1. mtime increments by 1 on each tick and wraps modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF → 0).
- A software write to mtime in the same cycle as a tick takes priority: mtime gets the written value, with no increment that cycle. The prescaler is not reset by mtime writes.
- timer_irq_o[i] is registered and equals (mtime ≥ mtimecmp[i]), unsigned. It is computed from the post-edge register values, so it is visible 1 cycle after the mtime or mtimecmp update.
- soft_irq_o[i] is registered and equals msip[i]. It is visible 1 cycle after the write edge.
- Writes of 0 to mtimecmp or mtime are legal. Writing mtimecmp=0 asserts timer_irq_o on the next cycle.

Decomposition:
- bp_common_pkg gains the following localparams:
  - clint_msip_offset_gp=16'h0000
  - clint_mtimecmp_offset_gp=16'h4000
  - clint_mtime_offset_gp=16'hBFF8
  - clint_hart_stride_gp=8
- The existing mtimecmp, mtime and ipi absolute addresses are retained and must stay consistent with these offsets.
- One sub-module, bp_clint_tick_gen: parametrised prescaler (div_p) producing tick_o, with clk_i and reset_i.
- The FSM, register file and comparators are inline.

Test Plan:
- Reset, then read 0xBFF8 with mtime_div_p=8 after 80 idle cycles → resp_data_o=10, resp_err_o=0; read 0x4008 → 0xFFFF_FFFF_FFFF_FFFF.
- Write mtimecmp[1] (0x4008)=20 with mtime at 5 and div=1 → timer_irq_o[1] rises the cycle after mtime reaches 20; other bits stay 0. Then write mtimecmp[1]=all-ones → bit 1 clears 1 cycle later.
- Write 0x0018=0x3 (msip[3]) → soft_irq_o=4'b1000 next cycle; read back → 0x1. Write 0 → bit clears.
- Write mtime=0xFFFF_FFFF_FFFF_FFFE with div=1 → reads over the following cycles show …FFFF, then 0 (wrap). Write mtime in the same cycle as a tick → readback equals the written value, not +1.
- Read 0x0020 with num_core_p=4, then read 0x8000 → both return data 0 with resp_err_o=1. Writes to the same offsets change no state.
- Hold resp_yumi_i=0 for 5 cycles → resp_v_o and resp_data_o stay stable and req_ready_o=0. Assert reset_i during RESP → resp_v_o=0 and req_ready_o=1 on the cycle after reset deasserts.
